// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the CPU owns the single-port memory, and a host may
// steal idle cycles through a four-phase request/acknowledge handshake.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_active,
  input  logic        cpu_mem_op,
  input  logic [7:0]  cpu_addr,
  input  logic        cpu_we,
  input  logic [15:0] cpu_dataout,
  output logic [15:0] cpu_datain,
  input  logic        h_req,
  input  logic        h_we,
  input  logic [7:0]  h_addr,
  input  logic [15:0] h_wdata,
  output logic        h_ack,
  output logic [15:0] h_rdata,
  output logic        h_starved,
  output logic [7:0]  m_addr,
  output logic        m_we,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state;
  logic        hold_we;
  logic [7:0]  hold_addr;
  logic [15:0] hold_wdata;
  logic [3:0]  wait_cnt;
  logic [3:0]  next_cnt;
  logic        free_slot;
  logic        grant;

  assign free_slot = !cpu_active || !cpu_mem_op;
  assign grant     = (state == WAIT) && free_slot;

  // The host only borrows the memory port during its grant cycle; the CPU sees no stall.
  assign m_addr     = grant ? hold_addr  : cpu_addr;
  assign m_wdata    = grant ? hold_wdata : cpu_dataout;
  assign m_we       = grant ? hold_we    : cpu_we;
  assign cpu_datain = m_rdata;

  assign next_cnt = (wait_cnt == LIMIT) ? wait_cnt : wait_cnt + 4'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      wait_cnt   <= '0;
      h_ack      <= 1'b0;
      h_rdata    <= '0;
      h_starved  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (h_req) begin
            hold_we    <= h_we;
            hold_addr  <= h_addr;
            hold_wdata <= h_wdata;
            wait_cnt   <= '0;
            h_starved  <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (free_slot) begin
            if (!hold_we) h_rdata <= m_rdata;
            h_ack     <= 1'b1;
            h_starved <= 1'b0;
            state     <= DONE;
          end else begin
            // h_starved is registered, so it is derived from the counter's next value.
            wait_cnt  <= next_cnt;
            h_starved <= (next_cnt == LIMIT);
          end
        end
        DONE: begin
          if (!h_req) begin
            h_ack <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          h_ack     <= 1'b0;
          h_starved <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural memory and a
// scoreboard of expected host read data.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_active, cpu_mem_op, cpu_we;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_dataout, cpu_datain;
  logic        h_req, h_we, h_ack, h_starved;
  logic [7:0]  h_addr;
  logic [15:0] h_wdata, h_rdata;
  logic [7:0]  m_addr;
  logic        m_we;
  logic [15:0] m_wdata, m_rdata;

  logic [15:0] mem [0:255];
  int          we_count = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q [$];
  logic [15:0] last_read;

  always #5 clock = ~clock;

  dmem_arbiter #(.STARVE_LIMIT(8)) dut (
    .clock(clock), .reset(reset),
    .cpu_active(cpu_active), .cpu_mem_op(cpu_mem_op), .cpu_addr(cpu_addr),
    .cpu_we(cpu_we), .cpu_dataout(cpu_dataout), .cpu_datain(cpu_datain),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_ack(h_ack), .h_rdata(h_rdata), .h_starved(h_starved),
    .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // Synchronous-write, asynchronous-read memory model.
  assign m_rdata = mem[m_addr];
  always @(posedge clock) begin
    if (m_we) begin
      mem[m_addr] <= m_wdata;
      we_count = we_count + 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [15:0] d);
    cpu_active = 1; cpu_mem_op = 1; cpu_we = 1; cpu_addr = a; cpu_dataout = d;
    tick();
    cpu_we = 0; cpu_active = 0; cpu_mem_op = 0;
  endtask

  task automatic host_start(input logic we, input logic [7:0] a, input logic [15:0] d);
    h_we = we; h_addr = a; h_wdata = d; h_req = 1;
  endtask

  task automatic wait_ack(output int edges);
    edges = 0;
    while (h_ack !== 1'b1 && edges < 50) begin
      tick();
      edges++;
    end
    checks++;
    if (h_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ack_timeout: h_ack=%b after %0d edges, required 1", h_ack, edges);
    end
  endtask

  task automatic check_read();
    logic [15:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: read completed with h_rdata=%h, no expectation queued", h_rdata);
    end else begin
      e = exp_q.pop_front();
      last_read = e;
      if (h_rdata !== e) begin
        errors++;
        $display("[TB] FAIL read_data: h_rdata=%h, required %h", h_rdata, e);
      end
    end
  endtask

  task automatic host_end();
    h_req = 0;
    tick();
    checks++;
    if (h_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ack_drop: h_ack=%b, required 0", h_ack);
    end
  endtask

  task automatic test_reset();
    reset = 0; h_req = 0; h_we = 0; h_addr = 0; h_wdata = 0;
    cpu_active = 0; cpu_mem_op = 0; cpu_we = 0; cpu_addr = 8'h55; cpu_dataout = 16'hA5A5;
    tick(); tick();
    checks++;
    if ({h_ack, h_starved, h_rdata} !== 18'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: ack=%b starved=%b rdata=%h, required 0 0 0000", h_ack, h_starved, h_rdata);
    end
    checks++;
    if (m_addr !== 8'h55 || m_wdata !== 16'hA5A5 || m_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_passthru: m_addr=%h m_wdata=%h m_we=%b, required 55 a5a5 0", m_addr, m_wdata, m_we);
    end
    reset = 1;
    tick();
  endtask

  // Free-slot write then read: one memory write, two-edge latency each.
  task automatic test_write_read();
    int n, base;
    cpu_active = 0;
    base = we_count;
    host_start(1, 8'h10, 16'hBEEF);
    wait_ack(n);
    checks++;
    if (n != 2) begin errors++; $display("[TB] FAIL write_latency: %0d edges, required 2", n); end
    checks++;
    if (we_count - base != 1) begin errors++; $display("[TB] FAIL write_count: %0d writes, required 1", we_count - base); end
    checks++;
    if (mem[8'h10] !== 16'hBEEF) begin errors++; $display("[TB] FAIL write_data: mem[10]=%h, required beef", mem[8'h10]); end
    host_end();
    base = we_count;
    exp_q.push_back(16'hBEEF);
    host_start(0, 8'h10, 16'h0000);
    wait_ack(n);
    checks++;
    if (n != 2) begin errors++; $display("[TB] FAIL read_latency: %0d edges, required 2", n); end
    check_read();
    checks++;
    if (we_count != base) begin errors++; $display("[TB] FAIL read_no_write: %0d writes, required 0", we_count - base); end
    host_end();
  endtask

  // CPU busy five cycles: host is held off, then served in the sixth.
  task automatic test_cpu_priority();
    int n;
    cpu_write(8'h20, 16'h1234);
    exp_q.push_back(16'h1234);
    cpu_active = 1; cpu_mem_op = 1; cpu_addr = 8'h77; cpu_we = 0;
    host_start(0, 8'h20, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (m_addr !== 8'h77 || h_ack !== 1'b0 || cpu_datain !== m_rdata) begin
        errors++;
        $display("[TB] FAIL cpu_priority: cycle %0d m_addr=%h ack=%b, required 77 0", i, m_addr, h_ack);
      end
    end
    cpu_mem_op = 0;
    #1;
    checks++;
    if (m_addr !== 8'h20 || m_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL grant_addr: m_addr=%h m_we=%b, required 20 0", m_addr, m_we);
    end
    wait_ack(n);
    checks++;
    if (n != 1) begin errors++; $display("[TB] FAIL grant_edge: %0d edges, required 1", n); end
    check_read();
    host_end();
    cpu_active = 0;
  endtask

  // Twelve busy WAIT cycles: h_starved rises after the eighth, clears on grant.
  task automatic test_starve();
    int n;
    logic exp_s;
    exp_q.push_back(16'hBEEF);
    cpu_active = 1; cpu_mem_op = 1;
    host_start(0, 8'h10, 16'h0000);
    tick();
    checks++;
    if (h_starved !== 1'b0) begin errors++; $display("[TB] FAIL starve_entry: h_starved=%b, required 0", h_starved); end
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_s = (i >= 8);
      checks++;
      if (h_starved !== exp_s) begin
        errors++;
        $display("[TB] FAIL starve_cycle: wait %0d h_starved=%b, required %b", i, h_starved, exp_s);
      end
    end
    cpu_mem_op = 0;
    wait_ack(n);
    checks++;
    if (h_starved !== 1'b0) begin errors++; $display("[TB] FAIL starve_clear: h_starved=%b, required 0", h_starved); end
    check_read();
    host_end();
    cpu_active = 0;
  endtask

  // Address/data changes in WAIT are ignored; a write leaves h_rdata alone.
  task automatic test_addr_change();
    int n;
    cpu_write(8'h31, 16'h0B0B);
    cpu_active = 1; cpu_mem_op = 1;
    host_start(1, 8'h30, 16'h4444);
    tick(); tick();
    h_addr = 8'h31; h_wdata = 16'h5555; h_we = 0;
    tick();
    cpu_mem_op = 0;
    wait_ack(n);
    checks++;
    if (mem[8'h30] !== 16'h4444 || mem[8'h31] !== 16'h0B0B) begin
      errors++;
      $display("[TB] FAIL held_addr: mem[30]=%h mem[31]=%h, required 4444 0b0b", mem[8'h30], mem[8'h31]);
    end
    checks++;
    if (h_rdata !== last_read) begin errors++; $display("[TB] FAIL rdata_hold: h_rdata=%h, required %h", h_rdata, last_read); end
    host_end();
    cpu_active = 0;
  endtask

  // Reset during WAIT of a write aborts it with no memory write.
  task automatic test_reset_abort();
    int base;
    cpu_write(8'h40, 16'h1111);
    cpu_active = 1; cpu_mem_op = 1; cpu_addr = 8'h66;
    host_start(1, 8'h40, 16'h9999);
    tick(); tick();
    base = we_count;
    cpu_mem_op = 0;
    reset = 0;
    #1;
    checks++;
    if (m_we !== 1'b0 || m_addr !== 8'h66 || h_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_immediate: m_we=%b m_addr=%h ack=%b, required 0 66 0", m_we, m_addr, h_ack);
    end
    h_req = 0;
    tick(); tick();
    reset = 1;
    tick(); tick();
    checks++;
    if (mem[8'h40] !== 16'h1111 || we_count != base || h_ack !== 1'b0 || m_addr !== 8'h66) begin
      errors++;
      $display("[TB] FAIL abort_result: mem[40]=%h writes=%0d ack=%b m_addr=%h, required 1111 0 0 66",
               mem[8'h40], we_count - base, h_ack, m_addr);
    end
    cpu_active = 0;
  endtask

  // h_req held after ack: ack stays high, no extra access; then a back-to-back read.
  task automatic test_back_to_back();
    int n, base;
    base = we_count;
    host_start(1, 8'h50, 16'hCAFE);
    wait_ack(n);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (h_ack !== 1'b1 || we_count - base != 1) begin
        errors++;
        $display("[TB] FAIL ack_hold: ack=%b writes=%0d, required 1 1", h_ack, we_count - base);
      end
    end
    host_end();
    exp_q.push_back(16'hCAFE);
    host_start(0, 8'h50, 16'h0000);
    wait_ack(n);
    checks++;
    if (n != 2) begin errors++; $display("[TB] FAIL b2b_latency: %0d edges, required 2", n); end
    check_read();
    host_end();
  endtask

  initial begin
    last_read = 16'h0000;
    test_reset();
    test_write_read();
    test_cpu_priority();
    test_starve();
    test_addr_change();
    test_reset_abort();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_leftover: %0d entries, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
